// File: rtl/digit_feature_decode.sv
// 3x3 glyph-code digit tracker with frame-stable locking.
// Overlays a sampling grid whose colour shows lock state.
module digit_feature_decode #(
    parameter int          POST_UP       = 80,
    parameter int          POST_DOWM     = 190,
    parameter int          POST_LEFT     = 70,
    parameter int          STABLE_FRAMES = 3,
    parameter logic [8:0]  DIG0          = 9'h1EF,
    parameter logic [8:0]  DIG1          = 9'h092,
    parameter logic [8:0]  DIG2          = 9'h193,
    parameter logic [8:0]  DIG3          = 9'h1F7,
    parameter logic [8:0]  DIG4          = 9'h13D,
    parameter logic [8:0]  DIG5          = 9'h0D6,
    parameter logic [8:0]  DIG6          = 9'h1F9,
    parameter logic [8:0]  DIG7          = 9'h127,
    parameter logic [8:0]  DIG8          = 9'h1FF,
    parameter logic [8:0]  DIG9          = 9'h13F,
    parameter logic [23:0] COLOR_LOCK    = 24'h00FF00,
    parameter logic [23:0] COLOR_SEARCH  = 24'hFF0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic [23:0] i_data,
    input  logic [8:0]  feature_code,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic [23:0] o_data,
    output logic [3:0]  digit,
    output logic        digit_valid
);

    localparam logic [3:0]  NOMATCH = 4'd15;
    localparam logic [3:0]  SF      = 4'(STABLE_FRAMES);
    localparam logic [11:0] Y_UP    = 12'(POST_UP);
    localparam logic [11:0] Y_M1    = 12'(POST_UP + 35);
    localparam logic [11:0] Y_M2    = 12'(POST_UP + 70);
    localparam logic [11:0] Y_DN    = 12'(POST_DOWM);
    localparam logic [11:0] X_C0    = 12'(POST_LEFT);
    localparam logic [11:0] X_C1    = 12'(POST_LEFT + 23);
    localparam logic [11:0] X_C2    = 12'(POST_LEFT + 46);
    localparam logic [11:0] X_C3    = 12'(POST_LEFT + 70);

    localparam logic [8:0] DIG_TAB [10] = '{
        DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7, DIG8, DIG9
    };

    typedef enum logic [1:0] {IDLE, TRACK, LOCK} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  digit_q, digit_d;
    logic        valid_q, valid_d;
    logic        vs_q;
    logic        hs_q, vso_q, de_q;
    logic [11:0] x_q, y_q;
    logic [23:0] data_q, data_d;

    logic        sample;
    logic [3:0]  match;
    logic [3:0]  cnt_inc;
    logic        x_in, y_in, col_hit, row_hit, grid;

    assign sample  = vs_q && !i_vs;
    assign cnt_inc = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;

    // Scan downward so the lowest matching index wins.
    always_comb begin
        match = NOMATCH;
        for (int i = 9; i >= 0; i--) begin
            if (feature_code == DIG_TAB[i]) match = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= 4'd15;
            cnt_q   <= 4'd0;
            digit_q <= 4'd15;
            valid_q <= 1'b0;
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            vso_q   <= 1'b0;
            de_q    <= 1'b0;
            x_q     <= 12'd0;
            y_q     <= 12'd0;
            data_q  <= 24'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            vs_q    <= i_vs;
            hs_q    <= i_hs;
            vso_q   <= i_vs;
            de_q    <= i_de;
            x_q     <= i_x;
            y_q     <= i_y;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (sample) begin
            if (match == NOMATCH) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end else if (state_q != IDLE && match == cand_q) begin
                cnt_d = cnt_inc;
                if (state_q == TRACK && cnt_inc == SF) state_d = LOCK;
            end else begin
                cand_d  = match;
                cnt_d   = 4'd1;
                state_d = (SF == 4'd1) ? LOCK : TRACK;
            end
        end
    end

    always_comb begin
        valid_d = (state_d == LOCK);
        digit_d = (state_d == LOCK) ? cand_d : digit_q;
    end

    always_comb begin
        x_in    = (i_x >= X_C0) && (i_x <= X_C3);
        y_in    = (i_y >= Y_UP) && (i_y <= Y_DN);
        col_hit = (i_x == X_C0) || (i_x == X_C1) ||
                  (i_x == X_C2) || (i_x == X_C3);
        row_hit = (i_y == Y_UP) || (i_y == Y_M1) ||
                  (i_y == Y_M2) || (i_y == Y_DN);
        grid    = (col_hit && y_in) || (row_hit && x_in);
        data_d  = grid ? (valid_d ? COLOR_LOCK : COLOR_SEARCH) : i_data;
    end

    assign o_hs        = hs_q;
    assign o_vs        = vso_q;
    assign o_de        = de_q;
    assign o_x         = x_q;
    assign o_y         = y_q;
    assign o_data      = data_q;
    assign digit       = digit_q;
    assign digit_valid = valid_q;

endmodule
